riscv_hart_fetch_sched: RTL and testbench

Fine-grained hart scheduler for the multithreaded fetch path. It picks which hart the fetch unit fetches for next, and sequences boot and debug halt. It also tracks the hart tag of the instruction held in IF, ID and EX, and drives those tags to the fetch unit and the decode/execute stages. It sits between the controller and the fetch unit.

---
 rtl/riscv_hart_fetch_sched.sv | 196 +++++++++++++++++++
 tb/tb_riscv_hart_fetch_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/riscv_hart_fetch_sched.sv
// Fine-grained hart scheduler for the multithreaded fetch path.
// Chooses the hart the fetch unit serves next (round-robin over eligible
// harts), sequences boot and debug halt, and tracks the hart tag and valid
// bit of the instruction in IF, ID and EX.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_en_i                 core fetch enable, leaves BOOT
//   halt_req_i                 debug halt request (level)
//   hart_active_i/hart_block_i per-hart enable / temporary fetch block
//   issue_ack_i                fetch unit delivered an instruction to IF
//   fetch_busy_i               fetch unit has a memory transaction outstanding
//   id_ready_i/ex_ready_i      stage advance enables
//   flush_ex_i                 taken branch in EX, flush younger of that hart
//   hart_fetch_o, req_o        scheduled hart and its fetch request
//   hart_id_IF/ID/EX_o         stage tags; stage_valid_o = {EX,ID,IF}
//   is_boot_o, boot_pc_set_o   boot state and one-cycle boot PC load
//   halt_if_o, halted_o        halt sequencing
//
// Optional feature macro RISCV_HART_SCHED_PRIO_EN adds prio_en_i/prio_hart_i:
// an eligible priority hart overrides the round-robin pick.
//
// The control outputs are decoded straight from the state register (and
// boot_pc_set_o/req_o from the current inputs) so that boot PC loading and
// fetch requests take effect in the same cycle.

module riscv_hart_fetch_sched #(
    parameter int unsigned NUM_THREADS       = 4,
    parameter int unsigned THREAD_ADDR_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef RISCV_HART_SCHED_PRIO_EN
    input  logic                         prio_en_i,
    input  logic [THREAD_ADDR_WIDTH-1:0] prio_hart_i,
`endif
    input  logic                         fetch_en_i,
    input  logic                         halt_req_i,
    input  logic [NUM_THREADS-1:0]       hart_active_i,
    input  logic [NUM_THREADS-1:0]       hart_block_i,
    input  logic                         issue_ack_i,
    input  logic                         fetch_busy_i,
    input  logic                         id_ready_i,
    input  logic                         ex_ready_i,
    input  logic                         flush_ex_i,
    output logic [THREAD_ADDR_WIDTH-1:0] hart_fetch_o,
    output logic                         req_o,
    output logic [THREAD_ADDR_WIDTH-1:0] hart_id_IF_o,
    output logic [THREAD_ADDR_WIDTH-1:0] hart_id_ID_o,
    output logic [THREAD_ADDR_WIDTH-1:0] hart_id_EX_o,
    output logic [2:0]                   stage_valid_o,
    output logic                         is_boot_o,
    output logic                         boot_pc_set_o,
    output logic                         halt_if_o,
    output logic                         halted_o
);

    localparam int unsigned TW = THREAD_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [TW-1:0]          hart_q, hart_nxt;
    logic [NUM_THREADS-1:0] eligible;
    logic                   any_elig;
    logic [TW-1:0]          rr_pick, rr_cand, sel;
    logic                   rr_found;

    logic [TW-1:0]          if_tag, id_tag, ex_tag;
    logic                   if_v, id_v, ex_v;
    logic                   if_v_f, id_v_f;

    assign eligible = hart_active_i & ~hart_block_i;
    assign any_elig = |eligible;

    // First eligible hart strictly after the current one; offset NUM_THREADS
    // wraps back onto the current hart so a sole eligible hart is kept.
    always_comb begin
        rr_pick  = hart_q;
        rr_cand  = hart_q;
        rr_found = 1'b0;
        for (int unsigned off = 1; off <= NUM_THREADS; off++) begin
            rr_cand = hart_q + TW'(off);
            if (!rr_found && eligible[rr_cand]) begin
                rr_pick  = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

`ifdef RISCV_HART_SCHED_PRIO_EN
    assign sel = (prio_en_i && eligible[prio_hart_i]) ? prio_hart_i : rr_pick;
`else
    assign sel = rr_pick;
`endif

    // State and scheduled-hart registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_BOOT;
            hart_q <= '0;
        end else begin
            state  <= state_nxt;
            hart_q <= hart_nxt;
        end
    end

    // Next state, hart reselection and state-decoded control outputs.
    always_comb begin
        state_nxt     = state;
        hart_nxt      = hart_q;
        is_boot_o     = 1'b0;
        boot_pc_set_o = 1'b0;
        req_o         = 1'b0;
        halt_if_o     = 1'b0;
        halted_o      = 1'b0;
        case (state)
            ST_BOOT: begin
                is_boot_o = 1'b1;
                if (fetch_en_i) begin
                    boot_pc_set_o = 1'b1;
                    state_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                req_o = eligible[hart_q];
                if (halt_req_i) state_nxt = ST_DRAIN;
                // Move on after an ack, or abandon an ineligible hart when
                // no transaction is in flight for it.
                if (any_elig && (issue_ack_i || (!eligible[hart_q] && !fetch_busy_i)))
                    hart_nxt = sel;
            end
            ST_DRAIN: begin
                halt_if_o = 1'b1;
                if (!fetch_busy_i) state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                halt_if_o = 1'b1;
                halted_o  = 1'b1;
                if (!halt_req_i) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Flush is applied to the pre-shift contents so flushed entries never move on.
    assign if_v_f = if_v & ~(flush_ex_i && (if_tag == ex_tag));
    assign id_v_f = id_v & ~(flush_ex_i && (id_tag == ex_tag));

    // Tag pipeline IF -> ID -> EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_tag <= '0;
            id_tag <= '0;
            ex_tag <= '0;
            if_v   <= 1'b0;
            id_v   <= 1'b0;
            ex_v   <= 1'b0;
        end else begin
            if (issue_ack_i) begin
                if_tag <= hart_q;
                if_v   <= 1'b1;
            end else if (id_ready_i) begin
                if_v   <= 1'b0;
            end else begin
                if_v   <= if_v_f;
            end

            if (id_ready_i) begin
                id_tag <= if_tag;
                id_v   <= if_v_f;
            end else if (ex_ready_i) begin
                id_v   <= 1'b0;
            end else begin
                id_v   <= id_v_f;
            end

            if (ex_ready_i) begin
                ex_tag <= id_tag;
                ex_v   <= id_v_f;
            end
        end
    end

    assign hart_fetch_o  = hart_q;
    assign hart_id_IF_o  = if_tag;
    assign hart_id_ID_o  = id_tag;
    assign hart_id_EX_o  = ex_tag;
    assign stage_valid_o = {ex_v, id_v, if_v};

endmodule

// File: tb/tb_riscv_hart_fetch_sched.sv
// Directed, table-driven bench for riscv_hart_fetch_sched.
module tb_riscv_hart_fetch_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_en = 1'b0, halt_req = 1'b0;
    logic [3:0] act = '0, blk = '0;
    logic       ack = 1'b0, busy = 1'b0, idr = 1'b0, exr = 1'b0, flush = 1'b0;
    logic [1:0] hart_fetch, tag_if, tag_id, tag_ex;
    logic       req, is_boot, bps, halt_if, halted;
    logic [2:0] sv;
`ifdef RISCV_HART_SCHED_PRIO_EN
    logic       prio_en = 1'b0;
    logic [1:0] prio_hart = '0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_hart_fetch_sched #(.NUM_THREADS(4), .THREAD_ADDR_WIDTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef RISCV_HART_SCHED_PRIO_EN
        .prio_en_i     (prio_en),
        .prio_hart_i   (prio_hart),
`endif
        .fetch_en_i    (fetch_en),
        .halt_req_i    (halt_req),
        .hart_active_i (act),
        .hart_block_i  (blk),
        .issue_ack_i   (ack),
        .fetch_busy_i  (busy),
        .id_ready_i    (idr),
        .ex_ready_i    (exr),
        .flush_ex_i    (flush),
        .hart_fetch_o  (hart_fetch),
        .req_o         (req),
        .hart_id_IF_o  (tag_if),
        .hart_id_ID_o  (tag_id),
        .hart_id_EX_o  (tag_ex),
        .stage_valid_o (sv),
        .is_boot_o     (is_boot),
        .boot_pc_set_o (bps),
        .halt_if_o     (halt_if),
        .halted_o      (halted)
    );

    typedef struct {
        logic       fen, halt;
        logic [3:0] act, blk;
        logic       ack, busy, idr, exr, flush;
        logic [1:0] hf;
        logic       req;
        logic [1:0] tif, tid, tex;
        logic [2:0] v;
        logic       boot, bps, hif, hlt;
    } vec_t;

    function automatic vec_t mk(
        input logic fen_a, input logic halt_a, input logic [3:0] act_a, input logic [3:0] blk_a,
        input logic ack_a, input logic busy_a, input logic idr_a, input logic exr_a, input logic flush_a,
        input logic [1:0] hf_a, input logic req_a, input logic [1:0] tif_a, input logic [1:0] tid_a,
        input logic [1:0] tex_a, input logic [2:0] v_a, input logic boot_a, input logic bps_a,
        input logic hif_a, input logic hlt_a);
        vec_t r;
        r.fen = fen_a; r.halt = halt_a; r.act = act_a; r.blk = blk_a;
        r.ack = ack_a; r.busy = busy_a; r.idr = idr_a; r.exr = exr_a; r.flush = flush_a;
        r.hf = hf_a; r.req = req_a; r.tif = tif_a; r.tid = tid_a; r.tex = tex_a; r.v = v_a;
        r.boot = boot_a; r.bps = bps_a; r.hif = hif_a; r.hlt = hlt_a;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Drive one cycle of inputs, then compare outputs before the next edge.
    task automatic apply(input vec_t t, input string nm);
        @(negedge clk);
        fetch_en = t.fen; halt_req = t.halt; act = t.act; blk = t.blk;
        ack = t.ack; busy = t.busy; idr = t.idr; exr = t.exr; flush = t.flush;
        #1;
        chk({nm, ".hart_fetch"},  {2'b0, hart_fetch}, {2'b0, t.hf});
        chk({nm, ".req"},         {3'b0, req},        {3'b0, t.req});
        chk({nm, ".tag_if"},      {2'b0, tag_if},     {2'b0, t.tif});
        chk({nm, ".tag_id"},      {2'b0, tag_id},     {2'b0, t.tid});
        chk({nm, ".tag_ex"},      {2'b0, tag_ex},     {2'b0, t.tex});
        chk({nm, ".valid"},       {1'b0, sv},         {1'b0, t.v});
        chk({nm, ".is_boot"},     {3'b0, is_boot},    {3'b0, t.boot});
        chk({nm, ".boot_pc_set"}, {3'b0, bps},        {3'b0, t.bps});
        chk({nm, ".halt_if"},     {3'b0, halt_if},    {3'b0, t.hif});
        chk({nm, ".halted"},      {3'b0, halted},     {3'b0, t.hlt});
    endtask

    vec_t tbl[21];

    initial begin
        // Boot, full round-robin, sparse harts, block, no eligible hart.
        tbl[0]  = mk(0,0,4'h0,4'h0, 0,0,0,0,0, 0,0, 0,0,0, 3'b000, 1,0,0,0);
        tbl[1]  = mk(0,0,4'h0,4'h0, 0,0,0,0,0, 0,0, 0,0,0, 3'b000, 1,0,0,0);
        tbl[2]  = mk(0,0,4'h0,4'h0, 0,0,0,0,0, 0,0, 0,0,0, 3'b000, 1,0,0,0);
        tbl[3]  = mk(1,0,4'h0,4'h0, 0,0,0,0,0, 0,0, 0,0,0, 3'b000, 1,1,0,0);
        tbl[4]  = mk(0,0,4'hF,4'h0, 0,0,1,1,0, 0,1, 0,0,0, 3'b000, 0,0,0,0);
        tbl[5]  = mk(0,0,4'hF,4'h0, 1,0,1,1,0, 0,1, 0,0,0, 3'b000, 0,0,0,0);
        tbl[6]  = mk(0,0,4'hF,4'h0, 1,0,1,1,0, 1,1, 0,0,0, 3'b001, 0,0,0,0);
        tbl[7]  = mk(0,0,4'hF,4'h0, 1,0,1,1,0, 2,1, 1,0,0, 3'b011, 0,0,0,0);
        tbl[8]  = mk(0,0,4'hF,4'h0, 1,0,1,1,0, 3,1, 2,1,0, 3'b111, 0,0,0,0);
        tbl[9]  = mk(0,0,4'hF,4'h0, 0,0,0,0,0, 0,1, 3,2,1, 3'b111, 0,0,0,0);
        tbl[10] = mk(0,0,4'hA,4'h0, 0,1,0,0,0, 0,0, 3,2,1, 3'b111, 0,0,0,0);
        tbl[11] = mk(0,0,4'hA,4'h0, 0,0,0,0,0, 0,0, 3,2,1, 3'b111, 0,0,0,0);
        tbl[12] = mk(0,0,4'hA,4'h0, 1,0,1,1,0, 1,1, 3,2,1, 3'b111, 0,0,0,0);
        tbl[13] = mk(0,0,4'hA,4'h0, 1,0,1,1,0, 3,1, 1,3,2, 3'b111, 0,0,0,0);
        tbl[14] = mk(0,0,4'hA,4'h2, 0,0,0,0,0, 1,0, 3,1,3, 3'b111, 0,0,0,0);
        tbl[15] = mk(0,0,4'hA,4'h2, 0,0,0,0,0, 3,1, 3,1,3, 3'b111, 0,0,0,0);
        tbl[16] = mk(0,0,4'h8,4'h0, 1,0,0,0,0, 3,1, 3,1,3, 3'b111, 0,0,0,0);
        tbl[17] = mk(0,0,4'h0,4'h0, 0,0,0,0,0, 3,0, 3,1,3, 3'b111, 0,0,0,0);
        tbl[18] = mk(0,0,4'h0,4'h0, 0,0,0,0,0, 3,0, 3,1,3, 3'b111, 0,0,0,0);
        tbl[19] = mk(0,0,4'h4,4'h0, 0,0,0,0,0, 3,0, 3,1,3, 3'b111, 0,0,0,0);
        tbl[20] = mk(0,0,4'h4,4'h0, 0,0,0,0,0, 2,1, 3,1,3, 3'b111, 0,0,0,0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset.is_boot", {3'b0, is_boot}, 4'h1);
        chk("reset.valid",   {1'b0, sv},      4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Fill all stages with hart 2, then flush with both stages advancing.
        apply(mk(0,0,4'h4,4'h0, 1,0,1,1,0, 2,1, 3,1,3, 3'b111, 0,0,0,0), "fl0");
        apply(mk(0,0,4'h4,4'h0, 1,0,1,1,0, 2,1, 2,3,1, 3'b111, 0,0,0,0), "fl1");
        apply(mk(0,0,4'h4,4'h0, 1,0,1,1,0, 2,1, 2,2,3, 3'b111, 0,0,0,0), "fl2");
        apply(mk(0,0,4'h4,4'h0, 0,0,1,1,1, 2,1, 2,2,2, 3'b111, 0,0,0,0), "fl3");
        apply(mk(0,0,4'hC,4'h0, 1,0,1,1,0, 2,1, 2,2,2, 3'b000, 0,0,0,0), "fl4");
        // Selective flush: IF holds hart 3 and survives; same-cycle ack for hart 2 is kept.
        apply(mk(0,0,4'hC,4'h0, 1,0,1,1,0, 3,1, 2,2,2, 3'b001, 0,0,0,0), "fl5");
        apply(mk(0,0,4'hC,4'h0, 1,0,0,0,1, 2,1, 3,2,2, 3'b011, 0,0,0,0), "fl6");
        apply(mk(0,0,4'hC,4'h0, 0,0,0,0,0, 3,1, 2,2,2, 3'b001, 0,0,0,0), "fl7");

        // Halt while a fetch is outstanding, then release.
        apply(mk(0,1,4'hC,4'h0, 0,1,0,0,0, 3,1, 2,2,2, 3'b001, 0,0,0,0), "h0");
        apply(mk(0,1,4'hC,4'h0, 0,1,0,0,0, 3,0, 2,2,2, 3'b001, 0,0,1,0), "h1");
        apply(mk(0,1,4'hC,4'h0, 0,1,0,0,0, 3,0, 2,2,2, 3'b001, 0,0,1,0), "h2");
        apply(mk(0,1,4'hC,4'h0, 0,0,0,0,0, 3,0, 2,2,2, 3'b001, 0,0,1,0), "h3");
        apply(mk(0,1,4'hC,4'h0, 0,0,0,0,0, 3,0, 2,2,2, 3'b001, 0,0,1,1), "h4");
        apply(mk(0,0,4'hC,4'h0, 0,0,0,0,0, 3,0, 2,2,2, 3'b001, 0,0,1,1), "h5");
        apply(mk(0,0,4'hC,4'h0, 0,0,0,0,0, 3,1, 2,2,2, 3'b001, 0,0,0,0), "h6");

        // Asynchronous reset away from a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.is_boot",    {3'b0, is_boot},    4'h1);
        chk("mid_rst.valid",      {1'b0, sv},         4'h0);
        chk("mid_rst.hart_fetch", {2'b0, hart_fetch}, 4'h0);
        chk("mid_rst.halt_if",    {3'b0, halt_if},    4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // halt_req_i is ignored in BOOT and on the boot transition.
        apply(mk(0,1,4'hF,4'h0, 0,0,0,0,0, 0,0, 0,0,0, 3'b000, 1,0,0,0), "b0");
        apply(mk(1,1,4'hF,4'h0, 0,0,0,0,0, 0,0, 0,0,0, 3'b000, 1,1,0,0), "b1");
        apply(mk(0,0,4'hF,4'h0, 0,0,0,0,0, 0,1, 0,0,0, 3'b000, 0,0,0,0), "b2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
